// File: rtl/pll_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pll_seq_pkg: state encoding and widths for the PLL reset sequencer |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package pll_seq_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] RESET_PLL = 3'd0;
  localparam logic [STATE_W-1:0] WAIT_LOCK = 3'd1;
  localparam logic [STATE_W-1:0] STABILIZE = 3'd2;
  localparam logic [STATE_W-1:0] RUN       = 3'd3;
  localparam logic [STATE_W-1:0] FAIL      = 3'd4;

  localparam int LOST_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    S_RESET_PLL = RESET_PLL,
    S_WAIT_LOCK = WAIT_LOCK,
    S_STABILIZE = STABILIZE,
    S_RUN       = RUN,
    S_FAIL      = FAIL
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_reset_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pll_reset_seq_if: lock/restart inputs and reset/status outputs    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface pll_reset_seq_if;
  import pll_seq_pkg::*;

  logic                  locked_i;
  logic                  restart_i;
  logic                  pll_rst_o;
  logic                  sys_rst_o;
  logic                  running_o;
  logic                  fail_o;
  logic [LOST_CNT_W-1:0] lost_count_o;

  // master is the sequencer itself, slave is the PLL/system side
  modport master (
    input  locked_i, restart_i,
    output pll_rst_o, sys_rst_o, running_o, fail_o, lost_count_o
  );

  modport slave (
    output locked_i, restart_i,
    input  pll_rst_o, sys_rst_o, running_o, fail_o, lost_count_o
  );

endinterface
`default_nettype wire

// File: rtl/cdc_sync2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cdc_sync2: generic 2-flop synchronizer, async active-high reset   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module cdc_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_reset_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pll_reset_seq: PLL reset pulse, lock wait/retry, lock qualification|
// | and system reset release with lock-loss counting.  Rev 1.0        |
// +------------------------------------------------------------------+
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRIES  = 4
) (
  input  logic            clk,
  input  logic            rst,
  pll_reset_seq_if.master bus
);

  localparam int c_cnt_max = max3(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
  localparam int c_retry_w = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;

  localparam logic [c_cnt_w-1:0]   c_rst_last     = c_cnt_w'(RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]   c_timeout_last = c_cnt_w'(LOCK_TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0]   c_stable_last  = c_cnt_w'(LOCK_STABLE - 1);
  localparam logic [c_retry_w-1:0] c_retry_last   = c_retry_w'(MAX_RETRIES - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [c_retry_w-1:0]  r_retry;
  logic [LOST_CNT_W-1:0] r_lost;
  logic                  r_pll_rst;
  logic                  r_sys_rst;
  logic                  r_running;
  logic                  r_fail;
  logic                  w_locked_s;
  logic                  w_retry_inc;
  logic                  w_retry_clr;
  logic                  w_lost_inc;
  logic                  w_cnt_clr;

  cdc_sync2 #(.WIDTH(1)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.locked_i),
    .o_q (w_locked_s)
  );

  always_comb begin
    w_next_state = r_state;
    w_retry_inc  = 1'b0;
    w_retry_clr  = 1'b0;
    w_lost_inc   = 1'b0;
    if (bus.restart_i) begin
      w_next_state = S_RESET_PLL;
      w_retry_clr  = 1'b1;
    end else begin
      case (r_state)
        S_RESET_PLL: begin
          if (r_cnt == c_rst_last) w_next_state = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (w_locked_s) begin
            w_next_state = S_STABILIZE;
          end else if (r_cnt == c_timeout_last) begin
            if (r_retry == c_retry_last) begin
              w_next_state = S_FAIL;
            end else begin
              w_next_state = S_RESET_PLL;
              w_retry_inc  = 1'b1;
            end
          end
        end
        S_STABILIZE: begin
          // a dropout restarts the lock wait but is not a new attempt
          if (!w_locked_s) begin
            w_next_state = S_WAIT_LOCK;
          end else if (r_cnt == c_stable_last) begin
            w_next_state = S_RUN;
            w_retry_clr  = 1'b1;
          end
        end
        S_RUN: begin
          if (!w_locked_s) begin
            w_next_state = S_RESET_PLL;
            w_lost_inc   = 1'b1;
          end
        end
        S_FAIL:  w_next_state = S_FAIL;
        default: w_next_state = S_RESET_PLL;
      endcase
    end
  end

  assign w_cnt_clr = bus.restart_i || (w_next_state != r_state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_RESET_PLL;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_lost    <= '0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_running <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_state <= w_next_state;

      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (r_state inside {S_RESET_PLL, S_WAIT_LOCK, S_STABILIZE}) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end

      if (w_retry_clr) begin
        r_retry <= '0;
      end else if (w_retry_inc) begin
        r_retry <= r_retry + c_retry_w'(1);
      end

      if (w_lost_inc && (r_lost != '1)) begin
        r_lost <= r_lost + LOST_CNT_W'(1);
      end

      // outputs follow the next state so they move on the same edge as it
      r_pll_rst <= (w_next_state == S_RESET_PLL) || (w_next_state == S_FAIL);
      r_sys_rst <= (w_next_state != S_RUN);
      r_running <= (w_next_state == S_RUN);
      r_fail    <= (w_next_state == S_FAIL);
    end
  end

  assign bus.pll_rst_o    = r_pll_rst;
  assign bus.sys_rst_o    = r_sys_rst;
  assign bus.running_o    = r_running;
  assign bus.fail_o       = r_fail;
  assign bus.lost_count_o = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pll_reset_seq: directed bench with cycle-stamped scoreboard    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_pll_reset_seq;
  import pll_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  pll_reset_seq_if bus();

  pll_reset_seq #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (32),
    .LOCK_STABLE  (8),
    .MAX_RETRIES  (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {pll_rst, sys_rst, running, fail, lost_count}
  logic [11:0] obs;
  assign obs = {bus.pll_rst_o, bus.sys_rst_o, bus.running_o, bus.fail_o, bus.lost_count_o};

  typedef struct {
    string       tag;
    int          at;
    logic [11:0] v;
  } exp_t;

  exp_t sbq[$];
  exp_t m_e;

  function automatic logic [11:0] pack(input logic p, input logic s, input logic r,
                                       input logic f, input int lost);
    return {p, s, r, f, 8'(lost)};
  endfunction

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] want);
    n_checks++;
    assert (got === want) else begin
      n_errors++;
      $error("FAIL %s: observed pll/sys/run/fail/lost=%h expected %h (cycle %0d)",
             tag, got, want, cyc);
    end
  endtask

  // expected output vector after rising edge number 'at'
  task automatic expect_at(input string tag, input int at, input logic p, input logic s,
                           input logic r, input logic f, input int lost);
    exp_t e;
    int   i;
    e.tag = tag;
    e.at  = at;
    e.v   = pack(p, s, r, f, lost);
    i = 0;
    while (i < sbq.size() && sbq[i].at <= at) i++;
    sbq.insert(i, e);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].at <= cyc) begin
      m_e = sbq.pop_front();
      if (m_e.at == cyc) begin
        check(m_e.tag, obs, m_e.v);
      end else begin
        n_checks++;
        n_errors++;
        $error("FAIL %s: observed no sample expected one at cycle %0d", m_e.tag, m_e.at);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b, c, d, r, lost_m;
    bus.locked_i  = 1'b0;
    bus.restart_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", obs, pack(1, 1, 0, 0, 0));

    // clean lock
    b = cyc;
    rst = 1'b0;
    expect_at("clean_pll_e1", b + 1, 1, 1, 0, 0, 0);
    expect_at("clean_pll_e3", b + 3, 1, 1, 0, 0, 0);
    expect_at("clean_pll_fall", b + 4, 0, 1, 0, 0, 0);
    wait_to(b + 10);
    bus.locked_i = 1'b1;
    expect_at("clean_hold", b + 20, 0, 1, 0, 0, 0);
    expect_at("clean_release", b + 21, 0, 0, 1, 0, 0);
    wait_to(b + 24);

    // repeated loss in RUN, saturating at 255
    lost_m = 0;
    for (int i = 0; i < 300; i++) begin
      c = cyc;
      bus.locked_i = 1'b0;
      expect_at("loss_pre", c + 2, 0, 0, 1, 0, lost_m);
      if (lost_m < 255) lost_m++;
      expect_at("loss_rise", c + 3, 1, 1, 0, 0, lost_m);
      expect_at("loss_relock_pre", c + 15, 0, 1, 0, 0, lost_m);
      expect_at("loss_relock", c + 16, 0, 0, 1, 0, lost_m);
      wait_to(c + 3);
      bus.locked_i = 1'b1;
      wait_to(c + 17);
    end

    // restart in RUN
    c = cyc;
    bus.restart_i = 1'b1;
    expect_at("restart_run", c + 1, 1, 1, 0, 0, 255);
    expect_at("restart_relock_pre", c + 13, 0, 1, 0, 0, 255);
    expect_at("restart_relock", c + 14, 0, 0, 1, 0, 255);
    wait_to(c + 1);
    bus.restart_i = 1'b0;
    wait_to(c + 16);

    // lock glitch during qualification
    c = cyc;
    bus.locked_i  = 1'b0;
    bus.restart_i = 1'b1;
    expect_at("glitch_restart", c + 1, 1, 1, 0, 0, 255);
    expect_at("glitch_stab", c + 13, 0, 1, 0, 0, 255);
    expect_at("glitch_wait", c + 14, 0, 1, 0, 0, 255);
    expect_at("glitch_hold", c + 24, 0, 1, 0, 0, 255);
    expect_at("glitch_release", c + 25, 0, 0, 1, 0, 255);
    wait_to(c + 1);
    bus.restart_i = 1'b0;
    wait_to(c + 6);
    bus.locked_i = 1'b1;
    wait_to(c + 11);
    bus.locked_i = 1'b0;
    wait_to(c + 14);
    bus.locked_i = 1'b1;
    wait_to(c + 28);

    // timeout, retries, FAIL, restart out of FAIL
    c = cyc;
    bus.locked_i  = 1'b0;
    bus.restart_i = 1'b1;
    expect_at("retry_restart", c + 1, 1, 1, 0, 0, 255);
    for (int a = 0; a < 3; a++) begin
      r = c + 1 + 36 * a;
      expect_at("retry_pll_hi", r + 3, 1, 1, 0, 0, 255);
      expect_at("retry_pll_lo", r + 4, 0, 1, 0, 0, 255);
      expect_at("retry_wait_end", r + 35, 0, 1, 0, 0, 255);
    end
    expect_at("fail_enter", c + 109, 1, 1, 0, 1, 255);
    expect_at("fail_hold", c + 119, 1, 1, 0, 1, 255);
    wait_to(c + 1);
    bus.restart_i = 1'b0;
    wait_to(c + 120);
    bus.restart_i = 1'b1;
    expect_at("fail_restart", c + 121, 1, 1, 0, 0, 255);
    expect_at("fresh_pll_hi", c + 124, 1, 1, 0, 0, 255);
    expect_at("fresh_pll_lo", c + 125, 0, 1, 0, 0, 255);
    expect_at("stab_before_rst", c + 131, 0, 1, 0, 0, 255);
    wait_to(c + 121);
    bus.restart_i = 1'b0;
    wait_to(c + 125);
    bus.locked_i = 1'b1;
    wait_to(c + 131);

    // async reset mid-STABILIZE
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", obs, pack(1, 1, 0, 0, 0));
    @(negedge clk);
    d = cyc;
    rst = 1'b0;
    expect_at("post_rst_pll_hi", d + 3, 1, 1, 0, 0, 0);
    expect_at("post_rst_pll_lo", d + 4, 0, 1, 0, 0, 0);
    expect_at("post_rst_hold", d + 12, 0, 1, 0, 0, 0);
    expect_at("post_rst_release", d + 13, 0, 0, 1, 0, 0);
    wait_to(d + 16);

    n_checks++;
    assert (sbq.size() == 0) else begin
      n_errors++;
      $error("FAIL sb_drain: observed %0d pending entries expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
